pattern_detector: RTL

- Parametrised serial bit-pattern detector, successor to the fixed single-pattern sequence detector.
- Pattern width is a parameter; pattern and don't-care mask are loadable at run time.
- Overlapping or non-overlapping matching is selectable, and a saturating match counter is kept.
- Sits on a serial bit stream behind any bit source with a valid strobe; `out_match` feeds downstream event logic.

---
 rtl/seq_det_pkg.sv | 18 +
 rtl/sat_counter.sv | 24 ++
 rtl/pattern_detector.sv | 75 +++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// Masked-equality compare is kept here so every user agrees on it.
package seq_det_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam logic [PAT_W_DEF-1:0] PAT_DEF = 4'b1001;

  // Operands are zero-extended by the caller; zero bits compare equal.
  function automatic logic masked_eq(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [63:0] m
  );
    return ((a ^ b) & m) == 64'd0;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear beats increment; the count sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  assign sat = &count;

  // Count events until full; clear or reset zeroes it.
  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (inc && !sat)
      count <= count + W'(1);
  end

endmodule

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector with loadable pattern/mask.
// Overlap select, registered match pulse, saturating count.
module pattern_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(PAT_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [PAT_W-1:0] mask_in,
  input  logic             overlap_en,
  input  logic             count_clr,
  output logic             out_match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_n;
  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] mask;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_n;
  logic             hit;

  // Next history/fill and the match decision for this cycle.
  always_comb begin
    hist_n = {hist[PAT_W-2:0], in_bit};
    fill_n = (fill == FULL) ? fill : fill + FW'(1);
    hit    = in_valid && !pat_load && (fill_n == FULL) &&
             masked_eq(64'(hist_n), 64'(pat), 64'(mask));
  end

  // Pattern, history and fill state; load beats a valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      pat       <= PAT_DEFAULT;
      mask      <= '1;
      fill      <= '0;
      out_match <= 1'b0;
    end else begin
      out_match <= hit;
      if (pat_load) begin
        pat  <= pat_in;
        mask <= mask_in;
        fill <= '0;
      end else if (in_valid) begin
        hist <= hist_n;
        fill <= (hit && !overlap_en) ? '0 : fill_n;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (hit),
    .clr  (count_clr),
    .count(match_count),
    .sat  (count_sat)
  );

endmodule
